morse_symbol_player: RTL and testbench
======================================

// Module: morse_symbol_player
// PURPOSE
//  Plays one Morse character as timed tone on/off intervals, paced by 1 ms ticks from the 1 ms LFSR timer.
//  Sits between the character ROM/game FSM (upstream) and the LED/buzzer driver (downstream).
//  Drives the timer's enable and consumes its timeout pulse.
// PARAMETERS
//  MAX_LEN   6    max elements per character; sym_len above this is clamped
//  DOT_MS    250  dot (unit) length in ms ticks
//  CNT_W     12   width of ms counter; must hold 7*DOT_MS-1
// PORTS
//  clk        in   1        system clock, single domain
//  rst        in   1        synchronous reset, active-high
//  sym_valid  in   1        character available from upstream
//  sym_ready  out  1        player can accept a character (IDLE only)
//  sym_len    in   3        number of elements, 0..7
//  sym_bits   in   MAX_LEN  element codes, bit0 played first; 1=dash, 0=dot
//  abort      in   1        cancel current character
//  ms_tick    in   1        1-cycle pulse per ms (timer OnemsTimeOut)
//  timer_en   out  1        enable for the 1 ms timer
//  tone_on    out  1        registered tone/LED drive
//  busy       out  1        high from accept until done/abort
//  done       out  1        1-cycle pulse when character plus tail gap complete
// BEHAVIOUR
//  Reset: state IDLE; tone_on=timer_en=busy=done=0; ms counter 0; sym_ready=0 while rst high, then 1.
//  States: IDLE, MARK, GAP, TAIL.
//  - IDLE: sym_ready=1. Accept on sym_valid&sym_ready: latch bits/len; len clamped to MAX_LEN.
//    - len=0: no tone; done pulses the cycle after accept; stays IDLE.
//  - MARK: tone_on=1 for DOT_MS (dot) or 3*DOT_MS (dash) ticks.
//    - Ends on the tick that makes the count equal target.
//    - Next state: GAP if more elements remain, else TAIL.
//  - GAP: tone_on=0 for 1*DOT_MS ticks, then MARK with the next element.
//  - TAIL: tone_on=0 for 3*DOT_MS ticks; exits to IDLE with done=1 on that cycle.
//  Signal behaviour:
//  - timer_en=1 in MARK/GAP/TAIL continuously; the timer is never restarted mid-character.
//  - ms_tick ignored in IDLE.
//  - Ms counter clears on every state change.
//  - Latency: accept at edge N -> tone_on=1 and timer_en=1 at edge N+1.
//  - busy=1 in MARK/GAP/TAIL, and for the len=0 cycle.
//  abort: priority over ms_tick.
//  - Next edge: IDLE, tone_on=0, timer_en=0, done NOT pulsed.
//  - abort in IDLE: no effect; an accept in the same cycle is still taken.
//  rst mid-operation: IDLE, all outputs 0, no done.
//  Simultaneous ms_tick and final-count on last element: single transition, no double count.
// CONFIGURATION
//  MORSE_WORD_GAP_EN defined:
//  - Added input word_end (1 bit), latched at accept.
//  - If set, TAIL lasts 7*DOT_MS ticks.
//  MORSE_WORD_GAP_EN undefined: no word_end port; TAIL always 3*DOT_MS.
// STRUCTURE
//  Package morse_pkg:
//  - state encoding constants
//  - DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7
//  Sub-module morse_unit_counter:
//  - counts ms_tick up to a loaded target; clears on load.
//  - outputs 1-cycle hit.
//  Top: FSM + element shift register + element index.
// TESTING (bench DOT_MS=2, ms_tick every 4 cycles)
//  - Reset held 3 cycles -> all outputs 0; after release sym_ready=1, no tone.
//  - sym_len=2, bits=2'b10 ("A": dot,dash):
//    - tone_on high 2 ticks, low 2, high 6, low 6.
//    - done one pulse; timer_en high throughout.
//  - sym_len=0 -> done pulse next cycle, tone_on never high, sym_ready back to 1.
//  - sym_len=7 (>MAX_LEN) bits=6'b111111 -> exactly 6 dashes played.
//  - abort during 2nd mark -> tone_on=0 and timer_en=0 next edge, no done, new char accepted.
//  - MORSE_WORD_GAP_EN, word_end=1, "E" -> mark 2 ticks then 14-tick tail before done.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol player: FSM state encoding and
// timing unit multipliers.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_GAP  = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 7;

    function automatic int unit_ms(input int units, input int dot_ms);
        return units * dot_ms;
    endfunction

endpackage

// File: rtl/morse_unit_counter.sv
// Counts ms ticks up to a target; hit is high on the tick that reaches it.
// A load clears the count and takes priority over a tick.
module morse_unit_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] target,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    assign hit = tick && ((count + CNT_W'(1)) == target);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (tick) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_symbol_player.sv
// Plays one Morse character as timed tone on/off intervals paced by 1 ms ticks.
// Optional MORSE_WORD_GAP_EN adds a word_end input that stretches the tail gap.
//
// state | meaning
// IDLE  | waiting for a character, sym_ready high
// MARK  | tone on for the current dot or dash
// GAP   | inter-element silence
// TAIL  | inter-character (or word) silence, then done
module morse_symbol_player
    import morse_pkg::*;
#(
    parameter int MAX_LEN = 6,
    parameter int DOT_MS  = 250,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [2:0]         sym_len,
    input  logic [MAX_LEN-1:0] sym_bits,
    input  logic               abort,
    input  logic               ms_tick,
`ifdef MORSE_WORD_GAP_EN
    input  logic               word_end,
`endif
    output logic               timer_en,
    output logic               tone_on,
    output logic               busy,
    output logic               done
);

    state_t             state;
    logic [MAX_LEN-1:0] bits_q;
    logic [2:0]         len_q;
    logic [2:0]         idx;
    logic [2:0]         len_clamped;
    logic [CNT_W-1:0]   target;
    logic [CNT_W-1:0]   tail_target;
    logic               accept;
    logic               cnt_load;
    logic               cnt_tick;
    logic               hit;

`ifdef MORSE_WORD_GAP_EN
    logic word_end_q;
    assign tail_target = word_end_q ? CNT_W'(unit_ms(WORD_GAP_UNITS, DOT_MS))
                                    : CNT_W'(unit_ms(CHAR_GAP_UNITS, DOT_MS));
`else
    assign tail_target = CNT_W'(unit_ms(CHAR_GAP_UNITS, DOT_MS));
`endif

    assign sym_ready   = (state == ST_IDLE) && !rst;
    assign accept      = sym_valid && sym_ready;
    assign len_clamped = (sym_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : sym_len;

    // Abort wins over a coincident tick, so the counter never sees that tick.
    assign cnt_tick = ms_tick && (state != ST_IDLE) && !abort;
    assign cnt_load = accept || ((state != ST_IDLE) && (abort || hit));

    always_comb begin
        target = '0;
        case (state)
            ST_MARK: target = bits_q[0] ? CNT_W'(unit_ms(DASH_UNITS, DOT_MS))
                                        : CNT_W'(DOT_MS);
            ST_GAP:  target = CNT_W'(unit_ms(ELEM_GAP_UNITS, DOT_MS));
            ST_TAIL: target = tail_target;
            default: target = '0;
        endcase
    end

    morse_unit_counter #(.CNT_W(CNT_W)) u_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .tick   (cnt_tick),
        .target (target),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bits_q   <= '0;
            len_q    <= '0;
            idx      <= '0;
            tone_on  <= 1'b0;
            timer_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            word_end_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                busy <= 1'b0;
                if (accept) begin
                    bits_q <= sym_bits;
                    len_q  <= len_clamped;
                    idx    <= '0;
                    busy   <= 1'b1;
`ifdef MORSE_WORD_GAP_EN
                    word_end_q <= word_end;
`endif
                    if (len_clamped == 3'd0) begin
                        done <= 1'b1;
                    end else begin
                        state    <= ST_MARK;
                        tone_on  <= 1'b1;
                        timer_en <= 1'b1;
                    end
                end
            end else if (abort) begin
                state    <= ST_IDLE;
                tone_on  <= 1'b0;
                timer_en <= 1'b0;
                busy     <= 1'b0;
            end else if (hit) begin
                case (state)
                    ST_MARK: begin
                        tone_on <= 1'b0;
                        state   <= (idx == len_q - 3'd1) ? ST_TAIL : ST_GAP;
                    end
                    ST_GAP: begin
                        state   <= ST_MARK;
                        tone_on <= 1'b1;
                        bits_q  <= bits_q >> 1;
                        idx     <= idx + 3'd1;
                    end
                    ST_TAIL: begin
                        state    <= ST_IDLE;
                        timer_en <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_symbol_player.sv
// Scoreboard bench for morse_symbol_player: expected tone run-lengths per
// character come from a reference model and are checked on each done pulse.
module tb_morse_symbol_player;

    localparam int DOT  = 2;
    localparam int MAXL = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic [2:0] sym_len = 3'd0;
    logic [5:0] sym_bits = 6'd0;
    logic       abort = 1'b0;
    logic       ms_tick = 1'b0;
    logic       sym_ready, timer_en, tone_on, busy, done;
`ifdef MORSE_WORD_GAP_EN
    logic       word_end = 1'b0;
`endif

    int    errors = 0;
    int    checks = 0;
    string exp_q[$];
    string acc = "";
    int    run_lvl = 0;
    int    run_n = 0;

    morse_symbol_player #(.MAX_LEN(MAXL), .DOT_MS(DOT), .CNT_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_len   (sym_len),
        .sym_bits  (sym_bits),
        .abort     (abort),
        .ms_tick   (ms_tick),
`ifdef MORSE_WORD_GAP_EN
        .word_end  (word_end),
`endif
        .timer_en  (timer_en),
        .tone_on   (tone_on),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One-cycle ms tick every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 ms_tick = 1'b1;
            @(posedge clk);
            #1 ms_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: a character is a list of (level, ticks) runs.
    function automatic string model(input int len, input logic [5:0] bits, input bit we);
        string s = "";
        int n = (len > MAXL) ? MAXL : len;
        if (n == 0) return s;
        for (int i = 0; i < n; i++) begin
            s = {s, $sformatf("1:%0d ", bits[i] ? 3 * DOT : DOT)};
            if (i < n - 1) s = {s, $sformatf("0:%0d ", DOT)};
        end
        s = {s, $sformatf("0:%0d ", (we ? 7 : 3) * DOT)};
        return s;
    endfunction

    task automatic flush();
        if (run_n > 0) acc = {acc, $sformatf("%0d:%0d ", run_lvl, run_n)};
        run_n = 0;
    endtask

    // Monitor: run-length encodes tone_on at ticks while the timer runs.
    initial begin
        string e;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc = "";
                run_n = 0;
            end else begin
                checks++;
                if (tone_on && !timer_en) begin
                    errors++;
                    $display("FAIL tone_without_timer actual=1 required=0");
                end
                if (done) begin
                    flush();
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected actual=done required=no_done");
                    end else begin
                        e = exp_q.pop_front();
                        if (acc != e) begin
                            errors++;
                            $display("FAIL char_pattern actual='%s' required='%s'", acc, e);
                        end
                    end
                    acc = "";
                end
                if (ms_tick && timer_en) begin
                    if (run_n > 0 && int'(tone_on) != run_lvl) flush();
                    run_lvl = int'(tone_on);
                    run_n++;
                end
                if (sym_valid && sym_ready) begin
                    acc = "";
                    run_n = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!sym_ready && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!sym_ready) check("ready_timeout", 32'(sym_ready), 32'd1);
    endtask

    task automatic send(input int len, input logic [5:0] bits, input bit we, input bit push);
        int n = (len > MAXL) ? MAXL : len;
        wait_ready();
        sym_valid = 1'b1;
        sym_len   = 3'(len);
        sym_bits  = bits;
`ifdef MORSE_WORD_GAP_EN
        word_end  = we;
`endif
        if (push) exp_q.push_back(model(len, bits, we));
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        if (n == 0) begin
            check("len0_done", 32'(done), 32'd1);
            check("len0_tone", 32'(tone_on), 32'd0);
            check("len0_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            check("len0_done_clear", 32'(done), 32'd0);
            check("len0_ready", 32'(sym_ready), 32'd1);
        end else begin
            check("accept_tone", 32'(tone_on), 32'd1);
            check("accept_timer", 32'(timer_en), 32'd1);
            check("accept_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t;
        bit we;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tone", 32'(tone_on), 32'd0);
        check("rst_timer", 32'(timer_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(sym_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(sym_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("idle_tone", 32'(tone_on), 32'd0);

        send(2, 6'b000010, 1'b0, 1'b1);
        drain();
        send(0, 6'b101010, 1'b0, 1'b1);
        drain();
        send(7, 6'b111111, 1'b0, 1'b1);
        drain();

        // Abort during the second mark: no done, outputs drop next edge.
        send(2, 6'b000010, 1'b0, 1'b0);
        t = 0;
        while (tone_on && t < 500) begin @(posedge clk); #1; t++; end
        while (!tone_on && t < 500) begin @(posedge clk); #1; t++; end
        check("abort_reached_mark2", 32'(tone_on), 32'd1);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_tone", 32'(tone_on), 32'd0);
        check("abort_timer", 32'(timer_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(sym_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        send(3, 6'b000101, 1'b0, 1'b1);
        drain();

        // Abort while idle must not block an accept in the same cycle.
        abort = 1'b1;
        send(1, 6'b000001, 1'b0, 1'b1);
        abort = 1'b0;
        drain();

        // Reset mid-character: everything drops, no done.
        send(2, 6'b000011, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tone", 32'(tone_on), 32'd0);
        check("midrst_timer", 32'(timer_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

`ifdef MORSE_WORD_GAP_EN
        send(1, 6'b000000, 1'b1, 1'b1);
        drain();
`endif

        for (int i = 0; i < 14; i++) begin
            we = 1'b0;
`ifdef MORSE_WORD_GAP_EN
            we = 1'($urandom_range(0, 1));
`endif
            send(int'($urandom_range(0, 7)), 6'($urandom), we, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
